// File: rtl/ui_defs.sv
// Shared UI constants: game state codes, button codes and the button rectangles that both the
// renderer and the click decoder read, in half-resolution (320x240) coordinates.
package ui_defs;

  // Mouse coordinates are full-res; the UI is laid out at half-res.
  localparam int unsigned UiScale = 1;

  typedef enum logic [3:0] {
    GsTitle    = 4'd0,
    GsStaff    = 4'd1,
    GsStage1   = 4'd2,
    GsSuccess1 = 4'd3,
    GsStage2   = 4'd4,
    GsSuccess2 = 4'd5,
    GsStage3   = 4'd6,
    GsSuccess3 = 4'd7,
    GsFail     = 4'd8,
    GsHelp     = 4'd9
  } game_state_e;

  typedef enum logic [2:0] {
    BtnNone   = 3'd0,
    BtnStage1 = 3'd1,
    BtnStage2 = 3'd2,
    BtnStage3 = 3'd3,
    BtnHelp   = 3'd4,
    BtnNext   = 3'd5,
    BtnBack   = 3'd6,
    BtnRetry  = 3'd7
  } btn_code_e;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StDead,
    StHoldoff
  } click_st_e;

  // Every button shares one column and one height.
  localparam logic [9:0] BtnX0 = 10'd120;
  localparam logic [9:0] BtnX1 = 10'd200;
  localparam logic [9:0] BtnH  = 10'd20;

  localparam logic [9:0] RowTitleStage1Y = 10'd120;
  localparam logic [9:0] RowTitleStage2Y = 10'd150;
  localparam logic [9:0] RowTitleStage3Y = 10'd180;
  localparam logic [9:0] RowTitleHelpY   = 10'd210;
  localparam logic [9:0] RowSuccNextY    = 10'd140;
  localparam logic [9:0] RowSuccBackY    = 10'd180;
  localparam logic [9:0] RowLastNextY    = 10'd150;
  localparam logic [9:0] RowFailRetryY   = 10'd140;
  localparam logic [9:0] RowFailBackY    = 10'd180;
  localparam logic [9:0] RowStaffBackY   = 10'd180;
  localparam logic [9:0] RowHelpBackY    = 10'd200;

  function automatic logic in_span(logic [9:0] v, logic [9:0] lo);
    return (v >= lo) && (v < lo + BtnH);
  endfunction

endpackage

// File: rtl/ui_hit_map.sv
// Combinational button hit test: which on-screen button (if any) lies under a full-res cursor
// position for the given game state. Locked stage buttons report no hit.
module ui_hit_map
  import ui_defs::*;
(
  input  logic [3:0] state_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [3:0] play_valid_i,
  output logic [2:0] btn_o
);

  logic [9:0] hx;
  logic [9:0] hy;
  logic       in_col;

  // Stages 0 and 1 are always playable, so only the upper unlock bits matter here.
  logic unused_pv;
  assign unused_pv = ^play_valid_i[1:0];

  always_comb begin
    hx     = x_i >> UiScale;
    hy     = y_i >> UiScale;
    in_col = (hx >= BtnX0) && (hx < BtnX1);
    btn_o  = BtnNone;
    if (in_col) begin
      case (game_state_e'(state_i))
        GsTitle: begin
          if (in_span(hy, RowTitleStage1Y)) begin
            btn_o = BtnStage1;
          end else if (in_span(hy, RowTitleStage2Y) && play_valid_i[2]) begin
            btn_o = BtnStage2;
          end else if (in_span(hy, RowTitleStage3Y) && play_valid_i[3]) begin
            btn_o = BtnStage3;
          end else if (in_span(hy, RowTitleHelpY)) begin
            btn_o = BtnHelp;
          end
        end
        GsSuccess1, GsSuccess2: begin
          if (in_span(hy, RowSuccNextY)) begin
            btn_o = BtnNext;
          end else if (in_span(hy, RowSuccBackY)) begin
            btn_o = BtnBack;
          end
        end
        GsSuccess3: begin
          if (in_span(hy, RowLastNextY)) begin
            btn_o = BtnNext;
          end
        end
        GsFail: begin
          if (in_span(hy, RowFailRetryY)) begin
            btn_o = BtnRetry;
          end else if (in_span(hy, RowFailBackY)) begin
            btn_o = BtnBack;
          end
        end
        GsStaff: begin
          if (in_span(hy, RowStaffBackY)) begin
            btn_o = BtnBack;
          end
        end
        GsHelp: begin
          if (in_span(hy, RowHelpBackY)) begin
            btn_o = BtnBack;
          end
        end
        default: btn_o = BtnNone;
      endcase
    end
  end

endmodule

// File: rtl/ui_click_decoder.sv
// Turns mouse position and raw left-button level into hover feedback and one-cycle button
// events for the game FSM: input regs, synchronizer, debouncer, click FSM and holdoff timer.
module ui_click_decoder
  import ui_defs::*;
#(
  parameter int unsigned DEB_CYCLES     = 1_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_left,
  input  logic [3:0] play_valid,
  output logic [2:0] hover_btn,
  output logic [2:0] btn_evt,
  output logic       btn_valid
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLDOFF_CYCLES + 1);

  // Stage 1 input registers and stage 2 hover register.
  logic [9:0] x_q, y_q;
  logic [3:0] gs_q;
  logic [2:0] hit;
  logic [2:0] hover_q;

  // Synchronizer and debouncer.
  logic            s1_q, s2_q;
  logic [1:0]      vld_q;
  logic            clean_q, clean_d;
  logic            lvl_q, lvl_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            mismatch, flip, press, release_evt;

  // Click FSM and outputs.
  click_st_e        fsm_q, fsm_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       evt_q, evt_d;
  logic             valid_q, valid_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             state_chg;

  ui_hit_map u_hit_map (
    .state_i      (gs_q),
    .x_i          (x_q),
    .y_i          (y_q),
    .play_valid_i (play_valid),
    .btn_o        (hit)
  );

  always_comb begin
    mismatch    = (s2_q != lvl_q);
    flip        = mismatch && (deb_cnt_q == DebW'(DEB_CYCLES - 1));
    deb_cnt_d   = (!mismatch || flip) ? '0 : deb_cnt_q + DebW'(1);
    lvl_d       = lvl_q ^ flip;
    press       = flip && !lvl_q;
    release_evt = flip && lvl_q;
    // A press only counts once a genuine low sample has been seen since reset, so a button
    // held through reset can never produce a click.
    clean_d     = clean_q | (vld_q[1] & ~s2_q);
  end

  always_comb begin
    fsm_d     = fsm_q;
    code_d    = code_q;
    evt_d     = evt_q;
    valid_d   = 1'b0;
    hold_d    = hold_q;
    state_chg = (state != gs_q);
    case (fsm_q)
      StIdle: begin
        if (press) begin
          if (clean_q && (hit != BtnNone)) begin
            fsm_d  = StArmed;
            code_d = hit;
          end else begin
            fsm_d = StDead;
          end
        end
      end
      StArmed: begin
        // Screen change aborts even when the release lands in the same cycle.
        if (state_chg) begin
          fsm_d = StDead;
        end else if (release_evt) begin
          if (hit == code_q) begin
            valid_d = 1'b1;
            evt_d   = code_q;
            hold_d  = '0;
            fsm_d   = StHoldoff;
          end else begin
            fsm_d = StIdle;
          end
        end
      end
      StDead: begin
        if (!lvl_q) begin
          fsm_d = StIdle;
        end
      end
      StHoldoff: begin
        if (hold_q == HoldW'(HOLDOFF_CYCLES - 1)) begin
          fsm_d = lvl_q ? StDead : StIdle;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      gs_q      <= '0;
      hover_q   <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      vld_q     <= '0;
      clean_q   <= 1'b0;
      lvl_q     <= 1'b0;
      deb_cnt_q <= '0;
      fsm_q     <= StIdle;
      code_q    <= '0;
      evt_q     <= '0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      x_q       <= mouse_x;
      y_q       <= mouse_y;
      gs_q      <= state;
      hover_q   <= hit;
      s1_q      <= mouse_left;
      s2_q      <= s1_q;
      vld_q     <= {vld_q[0], 1'b1};
      clean_q   <= clean_d;
      lvl_q     <= lvl_d;
      deb_cnt_q <= deb_cnt_d;
      fsm_q     <= fsm_d;
      code_q    <= code_d;
      evt_q     <= evt_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
    end
  end

  assign hover_btn = hover_q;
  assign btn_evt   = evt_q;
  assign btn_valid = valid_q;

endmodule

// File: tb/tb_ui_click_decoder.sv
// Scoreboard bench for ui_click_decoder: gestures are issued with their expected event queued
// from a rectangle-table model; monitors check events, held btn_evt and hover every cycle.
module tb_ui_click_decoder;

  localparam int Deb  = 4;
  localparam int Hold = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = '0;
  logic [9:0] mouse_x = '0;
  logic [9:0] mouse_y = '0;
  logic       mouse_left = 1'b0;
  logic [3:0] play_valid = '0;
  logic [2:0] hover_btn;
  logic [2:0] btn_evt;
  logic       btn_valid;

  always #5 clk = ~clk;

  ui_click_decoder #(
    .DEB_CYCLES     (Deb),
    .HOLDOFF_CYCLES (Hold)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .mouse_left (mouse_left),
    .play_valid (play_valid),
    .hover_btn  (hover_btn),
    .btn_evt    (btn_evt),
    .btn_valid  (btn_valid)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int last_evt = 0;

  int prev_st = 0, prev_x = 0, prev_y = 0;
  int last_st = 0, last_pv = 0, quiet = 0, exp_hover = 0;
  bit chk_hover = 1'b0, rst_edge = 1'b0;

  // Button rectangles in full-resolution screen pixels.
  function automatic int ref_hit(int st, logic [3:0] pv, int x, int y);
    if (x < 240 || x >= 400) return 0;
    case (st)
      0: begin
        if (y >= 240 && y < 280) return 1;
        if (y >= 300 && y < 340) return pv[2] ? 2 : 0;
        if (y >= 360 && y < 400) return pv[3] ? 3 : 0;
        if (y >= 420 && y < 460) return 4;
      end
      3, 5: begin
        if (y >= 280 && y < 320) return 5;
        if (y >= 360 && y < 400) return 6;
      end
      7: if (y >= 300 && y < 340) return 5;
      8: begin
        if (y >= 280 && y < 320) return 7;
        if (y >= 360 && y < 400) return 6;
      end
      1: if (y >= 360 && y < 400) return 6;
      9: if (y >= 400 && y < 440) return 6;
      default: return 0;
    endcase
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected hover: button under the cursor as sampled one edge earlier.
  initial forever begin
    @(posedge clk);
    chk_hover = !rst_n || (quiet >= 1 && int'(state) == last_st && int'(play_valid) == last_pv);
    exp_hover = !rst_n ? 0 : ref_hit(prev_st, play_valid, prev_x, prev_y);
    if (!rst_n || int'(state) != last_st || int'(play_valid) != last_pv) quiet = 0;
    else if (quiet < 3) quiet = quiet + 1;
    last_st  = int'(state);
    last_pv  = int'(play_valid);
    rst_edge = !rst_n;
    prev_st  = rst_n ? int'(state) : 0;
    prev_x   = rst_n ? int'(mouse_x) : 0;
    prev_y   = rst_n ? int'(mouse_y) : 0;
  end

  initial forever begin
    int e;
    @(negedge clk);
    if (chk_hover) check("hover", int'(hover_btn), exp_hover);
    if (rst_edge) begin
      last_evt = 0;
      check("rst_valid", int'(btn_valid), 0);
      check("rst_evt", int'(btn_evt), 0);
    end else if (btn_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_evt: got code %0d, expected no event (t=%0t)", btn_evt, $time);
      end else begin
        e = exp_q.pop_front();
        check("evt", int'(btn_evt), e);
        last_evt = e;
      end
    end else begin
      check("evt_hold", int'(btn_evt), last_evt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press at P, optionally drag to Q and/or switch screen mid-hold, then release.
  task automatic gesture(input int st, input int pv, input int px, input int py,
                         input int qx, input int qy, input int st2);
    int hp, hr;
    state = 4'(st); play_valid = 4'(pv); mouse_x = 10'(px); mouse_y = 10'(py);
    tick(4);
    hp = ref_hit(st, 4'(pv), px, py);
    hr = ref_hit(st2, 4'(pv), qx, qy);
    if (hp != 0 && hp == hr && st2 == st) exp_q.push_back(hp);
    mouse_left = 1'b1;
    tick(14);
    mouse_x = 10'(qx); mouse_y = 10'(qy); state = 4'(st2);
    tick(14);
    mouse_left = 1'b0;
    tick(Hold + Deb + 16);
  endtask

  task automatic glitch(input int n);
    mouse_left = 1'b1;
    tick(n);
    mouse_left = 1'b0;
    tick(12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int st_tab[9] = '{0, 1, 3, 5, 7, 8, 9, 2, 12};
    int bx[6]     = '{240, 239, 399, 400, 320, 240};
    int by[6]     = '{240, 240, 279, 240, 280, 239};
    int st, st2, px, py, qx, qy, pv;
    bit found;

    tick(3);
    rst_n = 1'b1;
    tick(3);

    gesture(0, 4'b0000, 320, 260, 320, 260, 0);
    gesture(0, 4'b0001, 320, 320, 320, 320, 0);
    gesture(0, 4'b0101, 320, 320, 320, 320, 0);
    gesture(8, 4'b0000, 320, 300, 320, 380, 8);
    gesture(3, 4'b0000, 0, 0, 320, 300, 3);
    for (int i = 0; i < 6; i++) gesture(0, 4'b1111, bx[i], by[i], bx[i], by[i], 0);

    state = 4'd0; mouse_x = 10'd320; mouse_y = 10'd260;
    tick(4);
    glitch(3);
    glitch(1);

    // Second click lands inside the holdoff window and must be dropped.
    exp_q.push_back(1);
    mouse_left = 1'b1;
    tick(14);
    mouse_left = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (btn_valid) found = 1'b1;
    end
    if (!found) check("holdoff_first_evt_seen", 0, 1);
    tick(1);
    mouse_left = 1'b1;
    tick(14);
    mouse_left = 1'b0;
    tick(Hold + Deb + 16);

    gesture(1, 4'b0000, 320, 380, 320, 380, 0);

    // Reset while pressed: nothing may fire, even after the held level is re-accepted.
    state = 4'd0; play_valid = 4'd0; mouse_x = 10'd320; mouse_y = 10'd260;
    tick(4);
    mouse_left = 1'b1;
    tick(12);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    mouse_left = 1'b0;
    tick(30);
    gesture(0, 4'b0000, 320, 260, 320, 260, 0);

    for (int i = 0; i < 45; i++) begin
      st = st_tab[$urandom_range(0, 8)];
      pv = int'($urandom_range(0, 15));
      px = int'($urandom_range(220, 420));
      py = int'($urandom_range(220, 479));
      if ($urandom_range(0, 2) == 0) begin
        qx = int'($urandom_range(220, 420));
        qy = int'($urandom_range(220, 479));
      end else begin
        qx = px;
        qy = py;
      end
      st2 = ($urandom_range(0, 6) == 0) ? st_tab[$urandom_range(0, 8)] : st;
      gesture(st, pv, px, py, qx, qy, st2);
      if ($urandom_range(0, 4) == 0) glitch(int'($urandom_range(1, 3)));
    end

    tick(20);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
